branch_predictor_btb: RTL and testbench

Parametrised branch predictor for the pipelined CPU: a direct-mapped branch target buffer plus a direction-prediction table, selectable between static, bimodal, and gshare modes. It sits beside the PC register. It supplies a next-PC prediction to IF combinationally, and accepts branch/jump resolution from the resolving stage. On resolution it flags mispredicts and supplies the corrected PC to the hazard control unit. It generalises the datapath's single on/off BRANCH_PREDICTOR choice into sized, mode-selectable hardware with optional statistics.

---
 rtl/bp_pkg.sv | 14 +
 rtl/bp_counter_table.sv | 48 ++++
 rtl/branch_predictor_btb.sv | 125 ++++++++++++
 tb/tb_branch_predictor_btb.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared constants for the branch predictor: mode encodings and the
// saturating-counter reset value.
package bp_pkg;

  localparam int BP_MODE_STATIC  = 0;
  localparam int BP_MODE_BIMODAL = 1;
  localparam int BP_MODE_GSHARE  = 2;

  // Weakly-not-taken: one below the taken threshold (0 for 1-bit counters).
  function automatic int ctr_reset_val(input int ctr_bits);
    return (1 << (ctr_bits - 1)) - 1;
  endfunction

endpackage

// File: rtl/bp_counter_table.sv
// Table of saturating direction counters: one combinational read port and
// one synchronous update port.
module bp_counter_table
  import bp_pkg::*;
#(
  parameter int ENTRIES  = 16,
  parameter int CTR_BITS = 2,
  parameter int IDX      = $clog2(ENTRIES)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [IDX-1:0]      rd_idx_i,
  output logic [CTR_BITS-1:0] rd_ctr_o,
  input  logic                upd_en_i,
  input  logic [IDX-1:0]      upd_idx_i,
  input  logic                upd_taken_i
);

  localparam logic [CTR_BITS-1:0] CTR_RST = CTR_BITS'(ctr_reset_val(CTR_BITS));
  localparam logic [CTR_BITS-1:0] CTR_MAX = '1;

  logic [CTR_BITS-1:0] ctr_q [ENTRIES];
  logic [CTR_BITS-1:0] ctr_cur;
  logic [CTR_BITS-1:0] ctr_d;

  assign rd_ctr_o = ctr_q[rd_idx_i];

  always_comb begin
    ctr_cur = ctr_q[upd_idx_i];
    ctr_d   = ctr_cur;
    if (upd_taken_i && (ctr_cur != CTR_MAX)) begin
      ctr_d = ctr_cur + CTR_BITS'(1);
    end else if (!upd_taken_i && (ctr_cur != '0)) begin
      ctr_d = ctr_cur - CTR_BITS'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_q[i] <= CTR_RST;
      end
    end else if (upd_en_i) begin
      ctr_q[upd_idx_i] <= ctr_d;
    end
  end

endmodule

// File: rtl/branch_predictor_btb.sv
// Direct-mapped BTB plus static/bimodal/gshare direction prediction.
// Define BP_STATS_EN to build the branch / mispredict statistics counters.
module branch_predictor_btb
  import bp_pkg::*;
#(
  parameter int WORD_SIZE   = 16,
  parameter int BTB_ENTRIES = 16,
  parameter int CTR_BITS    = 2,
  parameter int BP_MODE     = 2,
  localparam int IDX        = $clog2(BTB_ENTRIES)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [WORD_SIZE-1:0] pc,
  output logic                 pred_taken,
  output logic [WORD_SIZE-1:0] pred_target,
  output logic [IDX-1:0]       pred_hist,
  input  logic                 upd_valid,
  input  logic [WORD_SIZE-1:0] upd_pc,
  input  logic [WORD_SIZE-1:0] upd_target,
  input  logic                 upd_taken,
  input  logic                 upd_pred_taken,
  input  logic [WORD_SIZE-1:0] upd_pred_target,
  input  logic [IDX-1:0]       upd_hist,
  output logic                 mispredict,
  output logic [WORD_SIZE-1:0] correct_pc,
  output logic [WORD_SIZE-1:0] num_branch,
  output logic [WORD_SIZE-1:0] num_branch_miss
);

  localparam int  TAG_W     = WORD_SIZE - IDX;
  localparam bit  IS_GSHARE = (BP_MODE == BP_MODE_GSHARE);

  logic                 btb_valid_q [BTB_ENTRIES];
  logic [TAG_W-1:0]     btb_tag_q   [BTB_ENTRIES];
  logic [WORD_SIZE-1:0] btb_tgt_q   [BTB_ENTRIES];
  logic [IDX-1:0]       ghr_q, ghr_d;

  logic [IDX-1:0]      rd_idx, upd_idx, upd_hist_eff;
  logic [IDX-1:0]      ctr_rd_idx, ctr_upd_idx;
  logic [CTR_BITS-1:0] ctr_rd;
  logic                btb_hit;

  assign rd_idx       = pc[IDX-1:0];
  assign upd_idx      = upd_pc[IDX-1:0];
  assign upd_hist_eff = IS_GSHARE ? upd_hist : '0;

  // ghr_q is held at zero outside gshare, so the XOR degenerates to PC indexing.
  assign ctr_rd_idx  = rd_idx ^ ghr_q;
  assign ctr_upd_idx = upd_idx ^ upd_hist_eff;

  bp_counter_table #(
    .ENTRIES  (BTB_ENTRIES),
    .CTR_BITS (CTR_BITS),
    .IDX      (IDX)
  ) u_ctr_table (
    .clk         (clk),
    .rst_n       (reset_n),
    .rd_idx_i    (ctr_rd_idx),
    .rd_ctr_o    (ctr_rd),
    .upd_en_i    (upd_valid),
    .upd_idx_i   (ctr_upd_idx),
    .upd_taken_i (upd_taken)
  );

  assign btb_hit     = btb_valid_q[rd_idx] && (btb_tag_q[rd_idx] == pc[WORD_SIZE-1:IDX]);
  assign pred_taken  = (BP_MODE != BP_MODE_STATIC) && btb_hit && ctr_rd[CTR_BITS-1];
  assign pred_target = pred_taken ? btb_tgt_q[rd_idx] : pc + WORD_SIZE'(1);
  assign pred_hist   = ghr_q;

  assign mispredict = upd_valid &&
                      ((upd_taken != upd_pred_taken) ||
                       (upd_taken && upd_pred_taken && (upd_target != upd_pred_target)));
  assign correct_pc = upd_taken ? upd_target : upd_pc + WORD_SIZE'(1);

  always_comb begin
    ghr_d = ghr_q;
    if (IS_GSHARE && upd_valid) begin
      ghr_d = {ghr_q[IDX-2:0], upd_taken};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ghr_q <= '0;
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        btb_valid_q[i] <= 1'b0;
      end
    end else begin
      ghr_q <= ghr_d;
      if (upd_valid && upd_taken) begin
        btb_valid_q[upd_idx] <= 1'b1;
      end
    end
  end

  // Tag/target need no reset: they are only observed behind a set valid bit.
  always_ff @(posedge clk) begin
    if (upd_valid && upd_taken) begin
      btb_tag_q[upd_idx] <= upd_pc[WORD_SIZE-1:IDX];
      btb_tgt_q[upd_idx] <= upd_target;
    end
  end

`ifdef BP_STATS_EN
  logic [WORD_SIZE-1:0] num_branch_q, num_branch_miss_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      num_branch_q      <= '0;
      num_branch_miss_q <= '0;
    end else begin
      if (upd_valid) num_branch_q <= num_branch_q + WORD_SIZE'(1);
      if (mispredict) num_branch_miss_q <= num_branch_miss_q + WORD_SIZE'(1);
    end
  end

  assign num_branch      = num_branch_q;
  assign num_branch_miss = num_branch_miss_q;
`else
  assign num_branch      = '0;
  assign num_branch_miss = '0;
`endif

endmodule

// File: tb/tb_branch_predictor_btb.sv
// Self-checking bench: bimodal and gshare instances driven side by side,
// compared against an array-based reference model of the predictor rules.
module tb_branch_predictor_btb;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic [15:0] pc, upd_pc, upd_target;
  logic        upd_valid, upd_taken;
  logic        upd_pred_taken_b, upd_pred_taken_g;
  logic [15:0] upd_pred_target_b, upd_pred_target_g;
  logic [3:0]  upd_hist_b, upd_hist_g;

  logic        pred_taken_b, pred_taken_g, mispredict_b, mispredict_g;
  logic [15:0] pred_target_b, pred_target_g, correct_pc_b, correct_pc_g;
  logic [3:0]  pred_hist_b, pred_hist_g;
  logic [15:0] nb_b, nbm_b, nb_g, nbm_g;

  branch_predictor_btb #(.BP_MODE(1)) u_bim (
    .clk(clk), .reset_n(reset_n), .pc(pc),
    .pred_taken(pred_taken_b), .pred_target(pred_target_b), .pred_hist(pred_hist_b),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_target(upd_target), .upd_taken(upd_taken),
    .upd_pred_taken(upd_pred_taken_b), .upd_pred_target(upd_pred_target_b), .upd_hist(upd_hist_b),
    .mispredict(mispredict_b), .correct_pc(correct_pc_b),
    .num_branch(nb_b), .num_branch_miss(nbm_b)
  );

  branch_predictor_btb #(.BP_MODE(2)) u_gsh (
    .clk(clk), .reset_n(reset_n), .pc(pc),
    .pred_taken(pred_taken_g), .pred_target(pred_target_g), .pred_hist(pred_hist_g),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_target(upd_target), .upd_taken(upd_taken),
    .upd_pred_taken(upd_pred_taken_g), .upd_pred_target(upd_pred_target_g), .upd_hist(upd_hist_g),
    .mispredict(mispredict_g), .correct_pc(correct_pc_g),
    .num_branch(nb_g), .num_branch_miss(nbm_g)
  );

  int passed = 0, total = 0, fails = 0;

  // Reference model, index 0 = bimodal, 1 = gshare; 16 entries, 2-bit counters.
  int m_valid [2][16];
  int m_tag   [2][16];
  int m_tgt   [2][16];
  int m_ctr   [2][16];
  int m_ghr;
  int m_nb [2];
  int m_nm [2];
  bit obs_mp_g;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 16; i++) begin
        m_valid[m][i] = 0; m_tag[m][i] = 0; m_tgt[m][i] = 0; m_ctr[m][i] = 1;
      end
      m_nb[m] = 0; m_nm[m] = 0;
    end
    m_ghr = 0;
  endfunction

  function automatic void mpred(input int m, input int p, output int t, output int tg);
    int i, ci;
    bit hit;
    i   = p % 16;
    ci  = (m == 1) ? (i ^ m_ghr) : i;
    hit = (m_valid[m][i] != 0) && (m_tag[m][i] == p / 16);
    t   = (hit && m_ctr[m][ci] >= 2) ? 1 : 0;
    tg  = (t != 0) ? m_tgt[m][i] : (p + 1) % 65536;
  endfunction

  function automatic void model_update(input int p, input int t, input int tg, input int mp0, input int mp1);
    int i, ci;
    i = p % 16;
    for (int m = 0; m < 2; m++) begin
      ci = (m == 1) ? (i ^ m_ghr) : i;
      if (t != 0) begin
        m_valid[m][i] = 1; m_tag[m][i] = p / 16; m_tgt[m][i] = tg;
        if (m_ctr[m][ci] < 3) m_ctr[m][ci]++;
      end else if (m_ctr[m][ci] > 0) begin
        m_ctr[m][ci]--;
      end
      m_nb[m]++;
    end
    m_nm[0] += mp0;
    m_nm[1] += mp1;
    m_ghr = ((m_ghr << 1) | t) % 16;
  endfunction

  task automatic check_pred(input int p);
    int t, tg;
    mpred(0, p, t, tg);
    chk("bim_pred_taken", pred_taken_b, t);
    chk("bim_pred_target", pred_target_b, tg);
    chk("bim_pred_hist", pred_hist_b, 0);
    mpred(1, p, t, tg);
    chk("gsh_pred_taken", pred_taken_g, t);
    chk("gsh_pred_target", pred_target_g, tg);
    chk("gsh_pred_hist", pred_hist_g, m_ghr);
  endtask

  task automatic chk_stats();
`ifdef BP_STATS_EN
    chk("bim_num_branch", nb_b, m_nb[0] % 65536);
    chk("bim_num_miss", nbm_b, m_nm[0] % 65536);
    chk("gsh_num_branch", nb_g, m_nb[1] % 65536);
    chk("gsh_num_miss", nbm_g, m_nm[1] % 65536);
`else
    chk("bim_num_branch", nb_b, 0);
    chk("bim_num_miss", nbm_b, 0);
    chk("gsh_num_branch", nb_g, 0);
    chk("gsh_num_miss", nbm_g, 0);
`endif
  endtask

  task automatic probe(input logic [15:0] p);
    pc = p;
    upd_valid = 1'b0;
    #1;
    check_pred(int'(p));
    @(negedge clk);
  endtask

  // One resolution; prediction is fetched at the same pc so upd_pred/upd_hist
  // are what the predictor would have produced. exp_mp_b < 0 means no directed check.
  task automatic resolve(input logic [15:0] p, input bit t, input logic [15:0] tg, input int exp_mp_b);
    int pt0, ptg0, pt1, ptg1, mp0, mp1, cpc, pi, ti, tgi;
    pi = int'(p); ti = t ? 1 : 0; tgi = int'(tg);
    pc = p; upd_valid = 1'b1; upd_pc = p; upd_taken = t; upd_target = tg;
    mpred(0, pi, pt0, ptg0);
    mpred(1, pi, pt1, ptg1);
    upd_pred_taken_b = (pt0 != 0); upd_pred_target_b = ptg0[15:0]; upd_hist_b = 4'd0;
    upd_pred_taken_g = (pt1 != 0); upd_pred_target_g = ptg1[15:0]; upd_hist_g = m_ghr[3:0];
    mp0 = ((ti != pt0) || (ti == 1 && pt0 == 1 && tgi != ptg0)) ? 1 : 0;
    mp1 = ((ti != pt1) || (ti == 1 && pt1 == 1 && tgi != ptg1)) ? 1 : 0;
    cpc = (ti != 0) ? tgi : (pi + 1) % 65536;
    #1;
    check_pred(pi);
    chk("bim_mispredict", mispredict_b, mp0);
    chk("gsh_mispredict", mispredict_g, mp1);
    chk("bim_correct_pc", correct_pc_b, cpc);
    chk("gsh_correct_pc", correct_pc_g, cpc);
    if (exp_mp_b >= 0) chk("bim_mp_directed", mispredict_b, exp_mp_b);
    obs_mp_g = mispredict_g;
    @(posedge clk);
    model_update(pi, ti, tgi, mp0, mp1);
    @(negedge clk);
    upd_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    upd_valid = 1'b0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    int miss_cnt, late_cnt;
    reset_n = 1'b0; pc = 16'h0010; upd_valid = 1'b0; upd_pc = '0; upd_target = '0; upd_taken = 1'b0;
    upd_pred_taken_b = 1'b0; upd_pred_target_b = '0; upd_hist_b = '0;
    upd_pred_taken_g = 1'b0; upd_pred_target_g = '0; upd_hist_g = '0;
    model_reset();
    #2;
    chk("reset_bim_taken", pred_taken_b, 0);
    chk("reset_bim_target", pred_target_b, 16'h0011);
    chk("reset_gsh_taken", pred_taken_g, 0);
    chk("reset_gsh_target", pred_target_g, 16'h0011);
    chk_stats();
    @(negedge clk);
    reset_n = 1'b1;

    probe(16'hFFFF);
    chk("pc_wrap_target", pred_target_b, 16'h0000);

    // Learn one taken branch, then saturate and walk the counter back down.
    resolve(16'h0010, 1'b1, 16'h0040, 1);
    probe(16'h0010);
    chk("bim_learn_taken", pred_taken_b, 1);
    chk("bim_learn_target", pred_target_b, 16'h0040);
    resolve(16'h0010, 1'b1, 16'h0040, 0);
    repeat (3) resolve(16'h0010, 1'b1, 16'h0040, 0);
    resolve(16'h0010, 1'b0, 16'h0000, 1);
    probe(16'h0010);
    chk("sat_still_taken", pred_taken_b, 1);
    repeat (3) resolve(16'h0010, 1'b0, 16'h0000, -1);
    probe(16'h0010);
    chk("sat_no_wrap_taken", pred_taken_b, 0);
    chk("sat_no_wrap_target", pred_target_b, 16'h0011);

    resolve(16'h0012, 1'b1, 16'h0080, -1);
    probe(16'h0022);
    chk("alias_taken", pred_taken_b, 0);
    chk("alias_target", pred_target_b, 16'h0023);

    resolve(16'h0010, 1'b1, 16'h0040, 1);
    resolve(16'h0010, 1'b1, 16'h0040, 1);
    resolve(16'h0010, 1'b1, 16'h0050, 1);
    probe(16'h0010);
    chk("retarget_target", pred_target_b, 16'h0050);

    resolve(16'hFFFF, 1'b0, 16'h1234, -1);

    // Same index as 0x0010 with a new tag: same-cycle read must see the old entry.
    resolve(16'h0030, 1'b1, 16'h0099, 1);
    probe(16'h0030);
    chk("rbw_new_target", pred_target_b, 16'h0099);

    // Reset asserted across an update edge discards the update.
    @(negedge clk);
    pc = 16'h0050; upd_pc = 16'h0050; upd_taken = 1'b1; upd_target = 16'h0077; upd_valid = 1'b1;
    #2;
    reset_n = 1'b0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    upd_valid = 1'b0;
    reset_n = 1'b1;
    probe(16'h0050);
    chk("reset_discard_taken", pred_taken_b, 0);
    chk_stats();

    do_reset();
    miss_cnt = 0; late_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      resolve(16'h0040, (i % 2) == 0, 16'h0070, -1);
      if (obs_mp_g) begin
        miss_cnt++;
        if (i >= 10) late_cnt++;
      end
    end
    chk("gsh_late_misses", late_cnt, 0);
    chk("gsh_miss_pulses", miss_cnt, 3);
    chk_stats();
`ifdef BP_STATS_EN
    chk("gsh_num_branch_16", nb_g, 16);
    chk("gsh_num_miss_pulses", nbm_g, miss_cnt);
`endif

    for (int k = 0; k < 80; k++) begin
      resolve(16'($urandom_range(0, 63)), 1'($urandom_range(0, 1)), 16'($urandom), -1);
      if ($urandom_range(0, 3) == 0) probe(16'($urandom_range(0, 63)));
    end
    chk_stats();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
